rom_port_arbiter: RTL

//  Shares the single combinational read port of the instruction ROM between two requesters:

---
 rtl/rom_port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares the single combinational read port of the instruction ROM between
//   two requesters. Port 0 is instruction fetch and normally wins; port 1 is
//   the data/debug reader. A burst counter bounds how many fetches in a row
//   may be served while port 1 is waiting, so port 1 cannot be starved.
//   One request is granted per cycle. The ROM word is registered and returned
//   to the owning port one cycle after its handshake, together with a pulse.
//
// Ports
//   clk          clock, everything on the rising edge
//   rst          synchronous reset, active-high
//   req0_valid   port 0 request
//   req0_addr    port 0 word address (32 bits)
//   req0_ready   port 0 request accepted this cycle
//   rsp0_valid   port 0 response pulse, one cycle after handshake
//   rsp0_data    port 0 read data (0 when the address was out of range)
//   rsp0_err     port 0 address was out of range
//   req1_*       / rsp1_*   same meaning for port 1
//   rom_addr     word address to the ROM, 0 when nothing is granted
//   rom_data     ROM read data, combinational from rom_addr
module rom_port_arbiter #(
  parameter int ROM_SIZE  = 64,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic        rsp0_err,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        rsp1_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam int              CNT_W       = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
  localparam logic [31:0]     ROM_LIMIT   = 32'(ROM_SIZE);

  logic [CNT_W-1:0] burst_cnt;
  logic             grant0;
  logic             grant1;
  logic             addr_ok;

  // Fixed priority to port 0, except that once port 0 has been served
  // MAX_BURST times in a row while port 1 was waiting, port 1 gets the slot.
  // Nothing is granted while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || burst_cnt != BURST_LIMIT)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The ROM sees the granted address directly so its data is available in
  // the same cycle as the handshake.
  always_comb begin
    rom_addr = 32'd0;
    if (grant0) begin
      rom_addr = req0_addr;
    end else if (grant1) begin
      rom_addr = req1_addr;
    end
  end

  // Full 32-bit compare: high address bits must not alias back into the ROM.
  assign addr_ok = (rom_addr < ROM_LIMIT);

  // Response registers. Only the owning port pulses; the other port keeps its
  // last data word but drops valid and err. A reset drops any response that
  // was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp0_data  <= 32'd0;
      rsp1_valid <= 1'b0;
      rsp1_err   <= 1'b0;
      rsp1_data  <= 32'd0;
    end else begin
      rsp0_valid <= grant0;
      rsp0_err   <= grant0 && !addr_ok;
      rsp1_valid <= grant1;
      rsp1_err   <= grant1 && !addr_ok;
      if (grant0) begin
        rsp0_data <= addr_ok ? rom_data : 32'd0;
      end
      if (grant1) begin
        rsp1_data <= addr_ok ? rom_data : 32'd0;
      end
    end
  end

  // Counts consecutive port-0 grants while port 1 is waiting. It restarts as
  // soon as port 1 is served or stops asking, and saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (grant1 || !req1_valid) begin
      burst_cnt <= '0;
    end else if (grant0 && burst_cnt != BURST_LIMIT) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

endmodule
